sr_register_bank: RTL

//  Parametrised bank of WIDTH clocked SR flip-flops sharing one clock, async reset and an enable.

---
 rtl/sr_register_bank_pkg.sv | 31 +++
 rtl/sr_register_bank_if.sv | 29 ++
 rtl/sr_register_bank_sr_cell.sv | 29 ++
 rtl/sr_register_bank.sv | 83 ++++++++
 4 files changed

// File: rtl/sr_register_bank_pkg.sv
// Shared definitions for the SR flag register bank: S=R=1 resolution codes
// and the per-bit next-state function used by every cell.
package sr_pkg;

  localparam int SR_HOLD      = 0;
  localparam int SR_SET_DOM   = 1;
  localparam int SR_RESET_DOM = 2;
  localparam int SR_TOGGLE    = 3;

  // Next value of one SR bit; only the S=R=1 case depends on the mode.
  function automatic logic sr_next(input logic q, input logic s, input logic r,
                                   input int mode);
    logic nxt;
    nxt = q;
    case ({s, r})
      2'b00: nxt = q;
      2'b10: nxt = 1'b1;
      2'b01: nxt = 1'b0;
      default: begin
        case (mode)
          SR_SET_DOM:   nxt = 1'b1;
          SR_RESET_DOM: nxt = 1'b0;
          SR_TOGGLE:    nxt = ~q;
          default:      nxt = q;
        endcase
      end
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/sr_register_bank_if.sv
// Signal bundle between control logic (master) and the SR flag bank (slave).
// There is no handshake: every input is sampled on each rising clk edge, and
// all outputs are valid continuously (Q changes only on edges or reset).
interface sr_register_bank_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
);

  logic             en;
  logic [WIDTH-1:0] S;
  logic [WIDTH-1:0] R;
  logic             clr_flags;
  logic [WIDTH-1:0] Q;
  logic [WIDTH-1:0] Qbar;
  logic [WIDTH-1:0] conflict;
  logic             any_conflict;
  logic [CNT_W-1:0] conflict_cnt;

  modport master (
    output en, S, R, clr_flags,
    input  Q, Qbar, conflict, any_conflict, conflict_cnt
  );

  modport slave (
    input  en, S, R, clr_flags,
    output Q, Qbar, conflict, any_conflict, conflict_cnt
  );

endinterface

// File: rtl/sr_register_bank_sr_cell.sv
// One clocked SR flip-flop with enable, async reset to a per-bit value, and a
// combinational pulse marking an enabled S=R=1 cycle.
module sr_cell
  import sr_pkg::*;
#(
  parameter int MODE = SR_HOLD
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic s,
  input  logic r,
  input  logic rst_val,
  output logic q,
  output logic conflict_evt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= rst_val;
    end else if (en) begin
      q <= sr_next(q, s, r, MODE);
    end
  end

  // Conflict is reported regardless of MODE so dominant modes still get flagged.
  assign conflict_evt = en & s & r;

endmodule

// File: rtl/sr_register_bank.sv
// Bank of WIDTH SR flip-flops used as a set/clear flag register, with sticky
// per-channel conflict flags and a saturating count of conflicting cycles.
module sr_register_bank
  import sr_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter int               SR_MODE   = SR_HOLD,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int               CNT_W     = 4
) (
  input  logic                clk,
  input  logic                rst,
  sr_register_bank_if.slave   bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  if (SR_MODE < SR_HOLD || SR_MODE > SR_TOGGLE) begin : g_bad_mode
    $error("sr_register_bank: SR_MODE must be 0..3");
  end

  logic [WIDTH-1:0] q_vec;
  logic [WIDTH-1:0] evt_vec;
  logic [WIDTH-1:0] flags;
  logic [WIDTH-1:0] flags_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             any_evt;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    sr_cell #(
      .MODE (SR_MODE)
    ) u_cell (
      .clk          (clk),
      .rst          (rst),
      .en           (bus.en),
      .s            (bus.S[i]),
      .r            (bus.R[i]),
      .rst_val      (RESET_VAL[i]),
      .q            (q_vec[i]),
      .conflict_evt (evt_vec[i])
    );
  end

  assign any_evt = |evt_vec;

  // A fresh conflict on the same edge as clr_flags survives the clear.
  always_comb begin
    flags_next = bus.clr_flags ? '0 : flags;
    flags_next = flags_next | evt_vec;
  end

  always_comb begin
    cnt_next = cnt;
    if (any_evt) begin
      if (bus.clr_flags) begin
        cnt_next = CNT_ONE;
      end else if (cnt != CNT_MAX) begin
        cnt_next = cnt + CNT_ONE;
      end
    end else if (bus.clr_flags) begin
      cnt_next = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags <= '0;
      cnt   <= '0;
    end else begin
      flags <= flags_next;
      cnt   <= cnt_next;
    end
  end

  assign bus.Q            = q_vec;
  assign bus.Qbar         = ~q_vec;
  assign bus.conflict     = flags;
  assign bus.any_conflict = |flags;
  assign bus.conflict_cnt = cnt;

endmodule
